// File: rtl/arbiter_request_collector_if.sv
// Request/grant/offer bundle between the request collector, its arbiter and the downstream consumer.
interface arbiter_request_collector_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = 3
);
  logic [N-1:0]    req;
  logic [N-1:0]    pend;
  logic [N-1:0]    gnt;
  logic            valid;
  logic [IDXW-1:0] idx;
  logic            ready;
  logic            dup;
  logic            err;

  modport master (
    output req, gnt, ready,
    input  pend, valid, idx, dup, err
  );

  modport slave (
    input  req, gnt, ready,
    output pend, valid, idx, dup, err
  );
endinterface

// File: rtl/arbiter_request_collector.sv
// Sticky per-client pending bits feeding a lowest-index arbiter; the returned
// grant is re-registered as a VALID/IDX offer with a READY handshake.
module arbiter_request_collector #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = 3
) (
  input logic                    clk_i,
  input logic                    resetn_i,
  arbiter_request_collector_if.slave bus
);

  typedef enum logic [0:0] {IDLE, OFFER} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    p_q, p_d;
  logic [N-1:0]    g_q, g_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            dup_q, dup_d;
  logic            err_q, err_d;

  logic [N-1:0]    clr;
  logic [IDXW-1:0] enc;
  logic            gnt_onehot;
  logic            gnt_in_p;

  // Grant qualification and priority-free one-hot to binary encode
  always_comb begin
    enc        = '0;
    gnt_onehot = (bus.gnt != '0) && ((bus.gnt & (bus.gnt - N'(1))) == '0);
    gnt_in_p   = ((bus.gnt & ~p_q) == '0);
    for (int k = 0; k < N; k++) begin
      if (bus.gnt[k]) enc = enc | IDXW'(k);
    end
  end

  // Next-state, pending update and offer control
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    err_d   = err_q;
    clr     = '0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.gnt != '0) begin
          if (gnt_onehot && gnt_in_p) begin
            g_d     = bus.gnt;
            idx_d   = enc;
            valid_d = 1'b1;
            state_d = OFFER;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      OFFER: begin
        if (bus.ready) begin
          clr     = g_q;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set wins over clear when the served client re-requests on accept
    p_d   = (p_q & ~clr) | bus.req;
    dup_d = |(bus.req & p_q & ~clr);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      p_q     <= '0;
      g_q     <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      dup_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      g_q     <= g_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
    end
  end

  assign bus.pend  = p_q;
  assign bus.valid = valid_q;
  assign bus.idx   = idx_q;
  assign bus.dup   = dup_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_arbiter_request_collector.sv
// Directed bench for the request collector with a behavioural lowest-index arbiter in the loop.
module tb_arbiter_request_collector;

  localparam int unsigned N    = 8;
  localparam int unsigned IDXW = 3;

  logic clk;
  logic resetn;
  logic         force_en;
  logic [N-1:0] force_gnt;

  int n_cmp;
  int n_fail;

  arbiter_request_collector_if #(.N(N), .IDXW(IDXW)) bus ();

  arbiter_request_collector #(.N(N), .IDXW(IDXW)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus.slave)
  );

  // Arbiter model: isolate the lowest set bit of PEND, unless overridden
  assign bus.gnt = force_en ? force_gnt : (bus.pend & (~bus.pend + 8'd1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    bus.req   = '0;
    bus.ready = 1'b0;
    force_en  = 1'b0;
    force_gnt = '0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    bus.req   = 8'hFF;
    bus.ready = 1'b0;
    force_en  = 1'b0;
    force_gnt = '0;
    tick();
    n_cmp++;
    if (bus.pend !== 8'h00) begin n_fail++; $display("FAIL reset_pend got=%h exp=00", bus.pend); end
    n_cmp++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    n_cmp++;
    if (bus.err !== 1'b0 || bus.dup !== 1'b0) begin
      n_fail++; $display("FAIL reset_err_dup got=%b%b exp=00", bus.err, bus.dup);
    end
    bus.req = '0;
    resetn  = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus.req   = 8'h10;
    bus.ready = 1'b1;
    tick();
    bus.req = '0;
    n_cmp++;
    if (bus.pend !== 8'h10 || bus.valid !== 1'b0) begin
      n_fail++; $display("FAIL single_pend got=%h/%b exp=10/0", bus.pend, bus.valid);
    end
    tick();
    n_cmp++;
    if (bus.valid !== 1'b1 || bus.idx !== 3'd4) begin
      n_fail++; $display("FAIL single_offer got=%b/%0d exp=1/4", bus.valid, bus.idx);
    end
    tick();
    n_cmp++;
    if (bus.pend !== 8'h00 || bus.valid !== 1'b0) begin
      n_fail++; $display("FAIL single_clear got=%h/%b exp=00/0", bus.pend, bus.valid);
    end
  endtask

  task automatic test_priority_drain();
    logic [IDXW-1:0] exp_idx [4];
    exp_idx = '{3'd0, 3'd2, 3'd5, 3'd7};
    do_reset();
    bus.req   = 8'hA5;
    bus.ready = 1'b1;
    tick();
    bus.req = '0;
    n_cmp++;
    if (bus.pend !== 8'hA5) begin n_fail++; $display("FAIL drain_pend got=%h exp=a5", bus.pend); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.valid !== 1'b1 || bus.idx !== exp_idx[i]) begin
        n_fail++; $display("FAIL drain_offer%0d got=%b/%0d exp=1/%0d", i, bus.valid, bus.idx, exp_idx[i]);
      end
      tick();
      n_cmp++;
      if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL drain_bubble%0d got=%b exp=0", i, bus.valid); end
    end
    n_cmp++;
    if (bus.pend !== 8'h00) begin n_fail++; $display("FAIL drain_empty got=%h exp=00", bus.pend); end
  endtask

  task automatic test_backpressure_race();
    do_reset();
    bus.req   = 8'h08;
    bus.ready = 1'b0;
    tick();
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.valid !== 1'b1 || bus.idx !== 3'd3 || bus.pend !== 8'h08) begin
        n_fail++; $display("FAIL stall%0d got=%b/%0d/%h exp=1/3/08", i, bus.valid, bus.idx, bus.pend);
      end
    end
    bus.req   = 8'h08;
    bus.ready = 1'b1;
    tick();
    bus.req = '0;
    n_cmp++;
    if (bus.pend !== 8'h08 || bus.valid !== 1'b0 || bus.dup !== 1'b0) begin
      n_fail++; $display("FAIL race_keep got=%h/%b/%b exp=08/0/0", bus.pend, bus.valid, bus.dup);
    end
    tick();
    n_cmp++;
    if (bus.valid !== 1'b1 || bus.idx !== 3'd3) begin
      n_fail++; $display("FAIL race_reoffer got=%b/%0d exp=1/3", bus.valid, bus.idx);
    end
    tick();
    n_cmp++;
    if (bus.pend !== 8'h00) begin n_fail++; $display("FAIL race_clear got=%h exp=00", bus.pend); end
  endtask

  task automatic test_duplicate();
    int dup_cnt;
    int offer_cnt;
    dup_cnt   = 0;
    offer_cnt = 0;
    do_reset();
    bus.ready = 1'b1;
    bus.req   = 8'h02;
    tick();
    if (bus.dup === 1'b1) dup_cnt++;
    if (bus.valid === 1'b1) offer_cnt++;
    tick();
    bus.req = '0;
    if (bus.dup === 1'b1) dup_cnt++;
    if (bus.valid === 1'b1) offer_cnt++;
    n_cmp++;
    if (bus.dup !== 1'b1 || bus.valid !== 1'b1 || bus.idx !== 3'd1) begin
      n_fail++; $display("FAIL dup_pulse got=%b/%b/%0d exp=1/1/1", bus.dup, bus.valid, bus.idx);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.dup === 1'b1) dup_cnt++;
      if (bus.valid === 1'b1) offer_cnt++;
    end
    n_cmp++;
    if (dup_cnt != 1) begin n_fail++; $display("FAIL dup_count got=%0d exp=1", dup_cnt); end
    n_cmp++;
    if (offer_cnt != 1) begin n_fail++; $display("FAIL dup_offers got=%0d exp=1", offer_cnt); end
  endtask

  task automatic test_illegal_grant();
    do_reset();
    force_en  = 1'b1;
    force_gnt = '0;
    bus.ready = 1'b1;
    bus.req   = 8'h06;
    tick();
    bus.req = '0;
    n_cmp++;
    if (bus.pend !== 8'h06 || bus.valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_setup got=%h/%b exp=06/0", bus.pend, bus.valid);
    end
    force_gnt = 8'h06;
    tick();
    force_gnt = '0;
    n_cmp++;
    if (bus.err !== 1'b1 || bus.valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_err got=%b/%b exp=1/0", bus.err, bus.valid);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.err !== 1'b1 || bus.valid !== 1'b0 || bus.pend !== 8'h06) begin
      n_fail++; $display("FAIL illegal_sticky got=%b/%b/%h exp=1/0/06", bus.err, bus.valid, bus.pend);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_cmp++;
    if (bus.err !== 1'b0 || bus.pend !== 8'h00) begin
      n_fail++; $display("FAIL illegal_reset got=%b/%h exp=0/00", bus.err, bus.pend);
    end
    force_en = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    resetn    = 1'b0;
    bus.req   = '0;
    bus.ready = 1'b0;
    force_en  = 1'b0;
    force_gnt = '0;
    tick();
    test_reset();
    test_single();
    test_priority_drain();
    test_backpressure_race();
    test_duplicate();
    test_illegal_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
